// File: rtl/maxpool_if.sv
// Streaming handshake bundle between a conv stage, the max-pool block and its consumer.
// slave is the pooling block's view; master is the surrounding environment's view.
interface maxpool_if #(
    parameter int WIDTH = 16
) ();
    logic signed [WIDTH-1:0] s_data_in;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [WIDTH-1:0] m_data_out;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;

    modport slave (
        input  s_data_in, s_valid, m_ready,
        output s_ready, m_data_out, m_valid, m_last
    );

    modport master (
        output s_data_in, s_valid, m_ready,
        input  s_ready, m_data_out, m_valid, m_last
    );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 1-D max pooling over non-overlapping windows of POOL signed samples.
// LEN must be a multiple of POOL; m_last marks the final pooled result of each vector.
module maxpool_stream #(
    parameter int WIDTH = 16,
    parameter int LEN   = 32,
    parameter int POOL  = 2
) (
    input  logic     clk,
    input  logic     reset,
    maxpool_if.slave bus
);
    localparam int NOUT = LEN / POOL;
    localparam int CW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int OW   = (NOUT > 1) ? $clog2(NOUT) : 1;
    localparam logic [CW-1:0] WCNT_LAST = CW'(POOL - 1);
    localparam logic [OW-1:0] OCNT_LAST = OW'(NOUT - 1);

    logic [CW-1:0]           r_wcnt;
    logic [OW-1:0]           r_ocnt;
    logic signed [WIDTH-1:0] r_max;
    logic signed [WIDTH-1:0] r_data;
    logic                    r_valid;

    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_win_end;
    logic                    w_out_hs;
    logic signed [WIDTH-1:0] w_max;
    logic signed [WIDTH-1:0] w_result;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        // Only the window-closing sample needs the output slot, so stall just that one.
        w_s_ready = !reset && !((r_wcnt == WCNT_LAST) && r_valid && !bus.m_ready);
        w_accept  = bus.s_valid && w_s_ready;
        w_win_end = w_accept && (r_wcnt == WCNT_LAST);
        w_out_hs  = r_valid && bus.m_ready;
        w_max     = (bus.s_data_in > r_max) ? bus.s_data_in : r_max;
        w_result  = (POOL == 1) ? bus.s_data_in : w_max;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt  <= '0;
            r_ocnt  <= '0;
            r_max   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_wcnt == WCNT_LAST) begin
                    r_data <= w_result;
                    r_wcnt <= '0;
                end else if (r_wcnt == '0) begin
                    r_max  <= bus.s_data_in;
                    r_wcnt <= CW'(1);
                end else begin
                    r_max  <= w_max;
                    r_wcnt <= r_wcnt + CW'(1);
                end
            end

            // A completion in the same cycle as a handshake refills the slot with no bubble.
            if (w_win_end) begin
                r_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end

            if (w_out_hs) begin
                r_ocnt <= (r_ocnt == OCNT_LAST) ? '0 : r_ocnt + OW'(1);
            end
        end
    end

    assign bus.s_ready    = w_s_ready;
    assign bus.m_data_out = r_data;
    assign bus.m_valid    = r_valid;
    assign bus.m_last     = r_valid && (r_ocnt == OCNT_LAST);
endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: signed sample width.
REQ-002 The block SHALL have parameter LEN, default 32: samples per input vector (one conv output vector).
REQ-003 The block SHALL have parameter POOL, default 2: non-overlapping window size; LEN SHALL be a multiple of POOL, POOL>=1.
REQ-004 The block SHALL have port clk, input, 1: clock; all state updates on posedge clk.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have port s_data_in, input, WIDTH: signed sample from the upstream conv stage.
REQ-007 The block SHALL have port s_valid, input, 1: s_data_in valid.
REQ-008 The block SHALL have port s_ready, output, 1: block accepts a sample this cycle.
REQ-009 The block SHALL have port m_data_out, output, WIDTH: signed pooled result.
REQ-010 The block SHALL have port m_valid, output, 1: m_data_out valid.
REQ-011 The block SHALL have port m_ready, input, 1: downstream accepts m_data_out.
REQ-012 The block SHALL have port m_last, output, 1: high with the final pooled result of each vector (LEN/POOL-th).

Function
REQ-013 Input handshake SHALL occur on cycles with s_valid && s_ready; output handshake on m_valid && m_ready.
REQ-014 The block SHALL hold a window counter wcnt (0..POOL-1) and a signed running-max register.
REQ-015 Accepting a sample with wcnt==0 and POOL>1 SHALL load the running max with the sample and set wcnt=1.
REQ-016 Accepting a sample with 0<wcnt<POOL-1 SHALL set the running max to the signed max of itself and the sample, wcnt+1.
REQ-017 Accepting a sample with wcnt==POOL-1 SHALL load m_data_out with the signed max of running max and sample (the sample itself if POOL==1), set m_valid=1, and set wcnt=0.
REQ-018 Comparisons SHALL be two's-complement signed; on ties the value is unchanged (no width growth, no saturation needed).
REQ-019 s_ready SHALL be 0 only when wcnt==POOL-1 && m_valid && !m_ready; otherwise 1 (combinational from m_ready allowed).
REQ-020 An output handshake with no simultaneous window completion SHALL clear m_valid next cycle.
REQ-021 An output handshake coinciding with window completion SHALL keep m_valid=1 and present the new result next cycle (zero-bubble throughput).
REQ-022 m_data_out and m_last SHALL remain stable while m_valid && !m_ready.
REQ-023 The block SHALL hold an output counter ocnt (0..LEN/POOL-1), incremented on each output handshake, wrapping to 0 after LEN/POOL-1.
REQ-024 m_last SHALL equal m_valid && (ocnt==LEN/POOL-1).
REQ-025 Latency: a result SHALL be valid the cycle after the window's final sample is accepted.
REQ-026 Sustained throughput SHALL be one input sample per cycle when m_ready is held high.

Reset
REQ-027 While reset is high: m_valid=0, m_data_out=0, m_last=0, s_ready=0, wcnt=0, ocnt=0, running max=0.
REQ-028 Reset mid-window or mid-vector SHALL discard the partial window and pending output; the first sample after reset starts a new window and vector.
REQ-029 s_ready SHALL be 1 on the first cycle after reset deasserts.

Verification
REQ-030 POOL=2, m_ready=1, inputs 5,-3,-7,-2,100,100 -> outputs 5,-2,100 one cycle after each pair, no stall.
REQ-031 LEN=32, POOL=2, 32 samples back-to-back, m_ready=1 -> 16 outputs, m_last high only on 16th, then ocnt wraps and next vector's 16th also flags m_last.
REQ-032 Hold m_ready=0 after first output (value 9) with s_valid=1 -> s_ready drops when wcnt==1, m_data_out stays 9; raise m_ready -> handshake, next result follows with no lost or duplicated sample.
REQ-033 Inputs -32768,32767 -> output 32767; inputs -32768,-32768 -> output -32768.
REQ-034 Assert reset after 3 samples of a vector -> m_valid=0 next cycle; fresh vector of 32 samples yields 16 outputs with m_last on 16th.
REQ-035 Random s_valid/m_ready gaps over 10 vectors -> output stream matches reference model sample-for-sample.
